// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: ALU operations,
// opcode/funct constants and datapath mux select codes.
package mc_ctrl_pkg;

   localparam logic [4:0] ALU_NOP  = 5'b00000;
   localparam logic [4:0] ALU_ADDU = 5'b00001;
   localparam logic [4:0] ALU_SUBU = 5'b00010;
   localparam logic [4:0] ALU_ADD  = 5'b00011;
   localparam logic [4:0] ALU_SUB  = 5'b00100;
   localparam logic [4:0] ALU_OR   = 5'b00101;
   localparam logic [4:0] ALU_AND  = 5'b00110;
   localparam logic [4:0] ALU_SLT  = 5'b00111;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_ORI = 6'b001101;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;

   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_SLT  = 6'b101010;

   localparam logic [1:0] ASB_REGB   = 2'b00;
   localparam logic [1:0] ASB_FOUR   = 2'b01;
   localparam logic [1:0] ASB_IMM    = 2'b10;
   localparam logic [1:0] ASB_IMM_SH = 2'b11;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// R-type funct decoder: maps funct to an ALU operation and flags
// whether the funct is one the datapath supports.
module alu_dec
   import mc_ctrl_pkg::*;
#(
   parameter int FN_W = 6
) (
   input  logic [FN_W-1:0] funct,
   output logic [4:0]      alu_op,
   output logic            valid
);

   always_comb begin
      alu_op = ALU_NOP;
      valid  = 1'b1;
      case (funct)
         FN_ADDU: alu_op = ALU_ADDU;
         FN_SUBU: alu_op = ALU_SUBU;
         FN_ADD:  alu_op = ALU_ADD;
         FN_SUB:  alu_op = ALU_SUB;
         FN_OR:   alu_op = ALU_OR;
         FN_AND:  alu_op = ALU_AND;
         FN_SLT:  alu_op = ALU_SLT;
         default: valid  = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/
// writeback and drives every datapath select and enable each cycle.
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_FETCH  | read instruction at PC, PC+4 into PC when memory ready
// S_DCODE  | decode op/funct, branch target into ALUOut
// S_EXE    | ALU operation for R-type, ori, or address for lw/sw
// S_MEM_RD | load data read at ALUOut address
// S_MEM_WR | store data written at ALUOut address
// S_WB_ALU | ALUOut written to rd (R-type) or rt (ori)
// S_WB_MEM | MDR written to rt
// S_BRANCH | compare A-B, take branch target when Zero
// S_JUMP   | load jump target into PC
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int OP_W = 6,
   parameter int FN_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [OP_W-1:0] op,
   input  logic [FN_W-1:0] funct,
   input  logic            Zero,
   input  logic            mem_ready,
   output logic            mem_req,
   output logic            IorD,
   output logic            MemWrite,
   output logic            IRWrite,
   output logic            PCWrite,
   output logic [1:0]      PCSource,
   output logic            ALUSrcA,
   output logic [1:0]      ALUSrcB,
   output logic            EXTOp,
   output logic [4:0]      ALUOp,
   output logic            RegWrite,
   output logic            RegDst,
   output logic            MemtoReg,
   output logic            instr_done,
   output logic            illegal_instr
);

   typedef enum logic [3:0] {
      S_FETCH,
      S_DCODE,
      S_EXE,
      S_MEM_RD,
      S_MEM_WR,
      S_WB_ALU,
      S_WB_MEM,
      S_BRANCH,
      S_JUMP
   } state_t;

   state_t     state, state_nxt;
   logic [4:0] dec_op;
   logic       dec_valid;

   alu_dec #(.FN_W(FN_W)) u_alu_dec (
      .funct  (funct),
      .alu_op (dec_op),
      .valid  (dec_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      mem_req       = 1'b0;
      IorD          = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      PCWrite       = 1'b0;
      PCSource      = PCS_ALU;
      ALUSrcA       = 1'b0;
      ALUSrcB       = ASB_REGB;
      EXTOp         = 1'b0;
      ALUOp         = ALU_NOP;
      RegWrite      = 1'b0;
      RegDst        = 1'b0;
      MemtoReg      = 1'b0;
      instr_done    = 1'b0;
      illegal_instr = 1'b0;

      // Reset overrides everything so no write or request escapes
      if (rst) begin
         state_nxt = S_FETCH;
      end else begin
         case (state)
            S_FETCH: begin
               mem_req  = 1'b1;
               ALUSrcB  = ASB_FOUR;
               ALUOp    = ALU_ADDU;
               PCWrite  = mem_ready;
               IRWrite  = mem_ready;
               if (mem_ready) state_nxt = S_DCODE;
            end
            S_DCODE: begin
               ALUSrcB = ASB_IMM_SH;
               EXTOp   = 1'b1;
               ALUOp   = ALU_ADDU;
               case (op)
                  OP_R: begin
                     if (dec_valid) begin
                        state_nxt = S_EXE;
                     end else begin
                        illegal_instr = 1'b1;
                        state_nxt     = S_FETCH;
                     end
                  end
                  OP_ORI, OP_LW, OP_SW: state_nxt = S_EXE;
                  OP_BEQ:               state_nxt = S_BRANCH;
                  OP_J:                 state_nxt = S_JUMP;
                  default: begin
                     illegal_instr = 1'b1;
                     state_nxt     = S_FETCH;
                  end
               endcase
            end
            S_EXE: begin
               ALUSrcA = 1'b1;
               case (op)
                  OP_ORI: begin
                     ALUSrcB = ASB_IMM;
                     ALUOp   = ALU_OR;
                  end
                  OP_LW, OP_SW: begin
                     ALUSrcB = ASB_IMM;
                     EXTOp   = 1'b1;
                     ALUOp   = ALU_ADDU;
                  end
                  default: begin
                     ALUSrcB = ASB_REGB;
                     ALUOp   = dec_op;
                  end
               endcase
               if (op == OP_LW)      state_nxt = S_MEM_RD;
               else if (op == OP_SW) state_nxt = S_MEM_WR;
               else                  state_nxt = S_WB_ALU;
            end
            S_MEM_RD: begin
               mem_req = 1'b1;
               IorD    = 1'b1;
               if (mem_ready) state_nxt = S_WB_MEM;
            end
            S_MEM_WR: begin
               mem_req    = 1'b1;
               IorD       = 1'b1;
               MemWrite   = 1'b1;
               instr_done = mem_ready;
               if (mem_ready) state_nxt = S_FETCH;
            end
            S_WB_ALU: begin
               RegWrite   = 1'b1;
               RegDst     = (op == OP_R);
               instr_done = 1'b1;
               state_nxt  = S_FETCH;
            end
            S_WB_MEM: begin
               RegWrite   = 1'b1;
               MemtoReg   = 1'b1;
               instr_done = 1'b1;
               state_nxt  = S_FETCH;
            end
            S_BRANCH: begin
               ALUSrcA    = 1'b1;
               ALUSrcB    = ASB_REGB;
               ALUOp      = ALU_SUBU;
               PCSource   = PCS_ALUOUT;
               PCWrite    = Zero;
               instr_done = 1'b1;
               state_nxt  = S_FETCH;
            end
            S_JUMP: begin
               PCSource   = PCS_JUMP;
               PCWrite    = 1'b1;
               instr_done = 1'b1;
               state_nxt  = S_FETCH;
            end
            default: state_nxt = S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class cycle by cycle
// and compares the full output vector against hand-written expectations.
module tb_mc_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] op;
   logic [5:0] funct;
   logic       Zero;
   logic       mem_ready;
   logic       mem_req, IorD, MemWrite, IRWrite, PCWrite;
   logic [1:0] PCSource;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       EXTOp;
   logic [4:0] ALUOp;
   logic       RegWrite, RegDst, MemtoReg, instr_done, illegal_instr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mc_ctrl #(.OP_W(6), .FN_W(6)) dut (
      .clk           (clk),
      .rst           (rst),
      .op            (op),
      .funct         (funct),
      .Zero          (Zero),
      .mem_ready     (mem_ready),
      .mem_req       (mem_req),
      .IorD          (IorD),
      .MemWrite      (MemWrite),
      .IRWrite       (IRWrite),
      .PCWrite       (PCWrite),
      .PCSource      (PCSource),
      .ALUSrcA       (ALUSrcA),
      .ALUSrcB       (ALUSrcB),
      .EXTOp         (EXTOp),
      .ALUOp         (ALUOp),
      .RegWrite      (RegWrite),
      .RegDst        (RegDst),
      .MemtoReg      (MemtoReg),
      .instr_done    (instr_done),
      .illegal_instr (illegal_instr)
   );

   // Output vector layout:
   // {mem_req,IorD,MemWrite,IRWrite,PCWrite,PCSource[1:0],ALUSrcA,ALUSrcB[1:0],
   //  EXTOp,ALUOp[4:0],RegWrite,RegDst,MemtoReg,instr_done,illegal_instr}
   logic [20:0] obs;
   assign obs = {mem_req, IorD, MemWrite, IRWrite, PCWrite, PCSource, ALUSrcA,
                 ALUSrcB, EXTOp, ALUOp, RegWrite, RegDst, MemtoReg, instr_done,
                 illegal_instr};

   function automatic logic [20:0] ov(
      input logic mr, input logic iord, input logic mw, input logic irw,
      input logic pcw, input logic [1:0] pcs, input logic asa,
      input logic [1:0] asb, input logic ext, input logic [4:0] aop,
      input logic rw, input logic rd, input logic m2r, input logic done,
      input logic ill);
      return {mr, iord, mw, irw, pcw, pcs, asa, asb, ext, aop, rw, rd, m2r, done, ill};
   endfunction

   function automatic logic [20:0] e_fetch(input logic r);
      return ov(1, 0, 0, r, r, 2'b00, 0, 2'b01, 0, 5'd1, 0, 0, 0, 0, 0);
   endfunction
   function automatic logic [20:0] e_dcode(input logic ill);
      return ov(0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 1, 5'd1, 0, 0, 0, 0, ill);
   endfunction
   function automatic logic [20:0] e_exe(input logic [1:0] asb, input logic ext,
                                         input logic [4:0] aop);
      return ov(0, 0, 0, 0, 0, 2'b00, 1, asb, ext, aop, 0, 0, 0, 0, 0);
   endfunction
   function automatic logic [20:0] e_memrd();
      return ov(1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 5'd0, 0, 0, 0, 0, 0);
   endfunction
   function automatic logic [20:0] e_memwr(input logic r);
      return ov(1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 0, 5'd0, 0, 0, 0, r, 0);
   endfunction
   function automatic logic [20:0] e_wbalu(input logic rd);
      return ov(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 5'd0, 1, rd, 0, 1, 0);
   endfunction
   function automatic logic [20:0] e_wbmem();
      return ov(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 5'd0, 1, 0, 1, 1, 0);
   endfunction
   function automatic logic [20:0] e_branch(input logic z);
      return ov(0, 0, 0, 0, z, 2'b01, 1, 2'b00, 0, 5'd2, 0, 0, 0, 1, 0);
   endfunction
   function automatic logic [20:0] e_jump();
      return ov(0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 0, 5'd0, 0, 0, 0, 1, 0);
   endfunction

   // Drive inputs mid-cycle, let the combinational outputs settle, compare.
   task automatic step(input logic r, input logic mr, input logic z,
                       input logic [20:0] exp, input string tag);
      @(negedge clk);
      rst       = r;
      mem_ready = mr;
      Zero      = z;
      #1;
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; op = 6'b000000; funct = 6'b100001; Zero = 1'b0; mem_ready = 1'b1;

      step(1, 1, 1, 21'd0, "reset_zero");

      // addu
      op = 6'b000000; funct = 6'b100001;
      step(0, 1, 0, e_fetch(1),                "addu_fetch");
      step(0, 1, 0, e_dcode(0),                "addu_dcode");
      step(0, 1, 0, e_exe(2'b00, 0, 5'b00001), "addu_exe");
      step(0, 1, 0, e_wbalu(1),                "addu_wb");

      // lw with 2 fetch stalls and 3 read stalls: 10 cycles
      op = 6'b100011;
      step(0, 0, 0, e_fetch(0),                "lw_fetch_stall1");
      step(0, 0, 0, e_fetch(0),                "lw_fetch_stall2");
      step(0, 1, 0, e_fetch(1),                "lw_fetch_ready");
      step(0, 1, 0, e_dcode(0),                "lw_dcode");
      step(0, 1, 0, e_exe(2'b10, 1, 5'b00001), "lw_exe");
      step(0, 0, 0, e_memrd(),                 "lw_memrd_stall1");
      step(0, 0, 0, e_memrd(),                 "lw_memrd_stall2");
      step(0, 0, 0, e_memrd(),                 "lw_memrd_stall3");
      step(0, 1, 0, e_memrd(),                 "lw_memrd_ready");
      step(0, 1, 0, e_wbmem(),                 "lw_wbmem");

      // beq taken
      op = 6'b000100;
      step(0, 1, 1, e_fetch(1),  "beq1_fetch");
      step(0, 1, 1, e_dcode(0),  "beq1_dcode");
      step(0, 1, 1, e_branch(1), "beq1_branch_taken");
      // beq not taken
      step(0, 1, 0, e_fetch(1),  "beq0_fetch");
      step(0, 1, 0, e_dcode(0),  "beq0_dcode");
      step(0, 1, 0, e_branch(0), "beq0_branch_not_taken");

      // sw with two write stalls
      op = 6'b101011;
      step(0, 1, 0, e_fetch(1),                "sw_fetch");
      step(0, 1, 0, e_dcode(0),                "sw_dcode");
      step(0, 1, 0, e_exe(2'b10, 1, 5'b00001), "sw_exe");
      step(0, 0, 0, e_memwr(0),                "sw_memwr_stall1");
      step(0, 0, 0, e_memwr(0),                "sw_memwr_stall2");
      step(0, 1, 0, e_memwr(1),                "sw_memwr_ready");

      // ori: zero-extended immediate, OR, writes rt
      op = 6'b001101;
      step(0, 1, 0, e_fetch(1),                "ori_fetch");
      step(0, 1, 0, e_dcode(0),                "ori_dcode");
      step(0, 1, 0, e_exe(2'b10, 0, 5'b00101), "ori_exe");
      step(0, 1, 0, e_wbalu(0),                "ori_wb");

      // j
      op = 6'b000010;
      step(0, 1, 0, e_fetch(1), "j_fetch");
      step(0, 1, 0, e_dcode(0), "j_dcode");
      step(0, 1, 0, e_jump(),   "j_jump");

      // R-type slt and subu: ALUOp from funct
      op = 6'b000000; funct = 6'b101010;
      step(0, 1, 0, e_fetch(1),                "slt_fetch");
      step(0, 1, 0, e_dcode(0),                "slt_dcode");
      step(0, 1, 0, e_exe(2'b00, 0, 5'b00111), "slt_exe");
      step(0, 1, 0, e_wbalu(1),                "slt_wb");
      funct = 6'b100011;
      step(0, 1, 0, e_fetch(1),                "subu_fetch");
      step(0, 1, 0, e_dcode(0),                "subu_dcode");
      step(0, 1, 0, e_exe(2'b00, 0, 5'b00010), "subu_exe");
      step(0, 1, 0, e_wbalu(1),                "subu_wb");

      // illegal opcode: pulse in DCODE, back to FETCH (stalled to prove state)
      op = 6'b111111;
      step(0, 1, 0, e_fetch(1), "illop_fetch");
      step(0, 1, 0, e_dcode(1), "illop_dcode");
      step(0, 0, 0, e_fetch(0), "illop_back_to_fetch");
      // illegal funct
      op = 6'b000000; funct = 6'b000111;
      step(0, 1, 0, e_fetch(1), "illfn_fetch");
      step(0, 1, 0, e_dcode(1), "illfn_dcode");
      step(0, 0, 0, e_fetch(0), "illfn_back_to_fetch");

      // reset during MEM_RD abandons the load
      op = 6'b100011;
      step(0, 1, 0, e_fetch(1),                "rstlw_fetch");
      step(0, 1, 0, e_dcode(0),                "rstlw_dcode");
      step(0, 1, 0, e_exe(2'b10, 1, 5'b00001), "rstlw_exe");
      step(0, 0, 0, e_memrd(),                 "rstlw_memrd");
      step(1, 1, 1, 21'd0,                     "rstlw_reset_outputs");
      step(0, 0, 0, e_fetch(0),                "rstlw_after_reset_fetch");
      step(0, 1, 0, e_fetch(1),                "rstlw_refetch_ready");
      step(0, 1, 0, e_dcode(0),                "rstlw_redcode");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
